// File: rtl/envelope_adsr.sv
// Per-voice ADSR amplitude envelope.
// Scales an unsigned, mid-centred oscillator sample about its centre code by a
// gated attack/decay/sustain/release envelope. One step per sample_clock_i edge.
//
// Ports:
//   sample_clock_i   sample-rate clock, rising edge
//   rst_ni           synchronous active-low reset
//   gate_i           note on/off, level-sensitive; rising edge detected internally
//   attack_rate_i    per-sample increment while attacking
//   decay_rate_i     per-sample decrement while decaying
//   sustain_level_i  sustain gain, tracked live while sustaining
//   release_rate_i   per-sample decrement while releasing
//   osc_in_i         unsigned oscillator sample, Center = silence
//   out_o            enveloped sample, unsigned, Center = silence (2-cycle latency)
//   env_level_o      top EnvBits of the envelope accumulator
//   state_o          Idle=0 Attack=1 Decay=2 Sustain=3 Release=4
//   busy_o           state_o != Idle
module envelope_adsr #(
    parameter int unsigned BitDepth = 12,
    parameter int unsigned EnvBits  = 8,
    parameter int unsigned AccBits  = 16
) (
    input  logic                sample_clock_i,
    input  logic                rst_ni,
    input  logic                gate_i,
    input  logic [AccBits-1:0]  attack_rate_i,
    input  logic [AccBits-1:0]  decay_rate_i,
    input  logic [EnvBits-1:0]  sustain_level_i,
    input  logic [AccBits-1:0]  release_rate_i,
    input  logic [BitDepth-1:0] osc_in_i,
    output logic [BitDepth-1:0] out_o,
    output logic [EnvBits-1:0]  env_level_o,
    output logic [2:0]          state_o,
    output logic                busy_o
);

    localparam logic [BitDepth-1:0] Center = BitDepth'((1 << (BitDepth - 1)) - 1);
    localparam logic [AccBits-1:0]  EnvMax = '1;
    localparam int unsigned         ProdW  = BitDepth + EnvBits + 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [AccBits-1:0] env_acc_q, env_acc_d;
    logic               gate_q;

    logic               rise;
    logic [AccBits-1:0] sus_acc;
    logic [AccBits:0]   atk_sum;
    logic [AccBits:0]   dec_lim;

    assign rise    = gate_i & ~gate_q;
    assign sus_acc = {sustain_level_i, {(AccBits - EnvBits){1'b0}}};
    // One extra bit so the attack overshoot and decay limit never wrap.
    assign atk_sum = {1'b0, env_acc_q} + {1'b0, attack_rate_i};
    assign dec_lim = {1'b0, sus_acc} + {1'b0, decay_rate_i};

    always_comb begin
        state_d   = state_q;
        env_acc_d = env_acc_q;
        unique case (state_q)
            StIdle: begin
                env_acc_d = '0;
                if (rise) begin
                    state_d = StAttack;
                end
            end
            StAttack: begin
                // Gate drop wins over the step: release starts from the held level.
                if (!gate_i) begin
                    state_d = StRelease;
                end else if (atk_sum >= {1'b0, EnvMax}) begin
                    env_acc_d = EnvMax;
                    state_d   = StDecay;
                end else begin
                    env_acc_d = atk_sum[AccBits-1:0];
                end
            end
            StDecay: begin
                if (!gate_i) begin
                    state_d = StRelease;
                end else if ({1'b0, env_acc_q} <= dec_lim) begin
                    env_acc_d = sus_acc;
                    state_d   = StSustain;
                end else begin
                    env_acc_d = env_acc_q - decay_rate_i;
                end
            end
            StSustain: begin
                if (!gate_i) begin
                    state_d = StRelease;
                end else begin
                    env_acc_d = sus_acc;
                end
            end
            StRelease: begin
                // Retrigger keeps the current level rather than restarting from zero.
                if (rise) begin
                    state_d = StAttack;
                end else if (env_acc_q <= release_rate_i) begin
                    env_acc_d = '0;
                    state_d   = StIdle;
                end else begin
                    env_acc_d = env_acc_q - release_rate_i;
                end
            end
            default: begin
                state_d   = StIdle;
                env_acc_d = '0;
            end
        endcase
    end

    always_ff @(posedge sample_clock_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            env_acc_q <= '0;
            gate_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            env_acc_q <= env_acc_d;
            gate_q    <= gate_i;
        end
    end

    assign env_level_o = env_acc_q[AccBits-1 -: EnvBits];
    assign state_o     = state_q;
    assign busy_o      = (state_q != StIdle);

    // Two-stage scaling datapath: register the signed offset and gain, then
    // multiply, floor-shift and re-centre.
    logic signed [BitDepth:0] diff_q, diff_d;
    logic [EnvBits-1:0]       e_q;
    logic signed [ProdW-1:0]  prod;
    logic signed [ProdW-1:0]  scaled;
    logic [BitDepth-1:0]      out_q, out_d;

    assign diff_d = $signed({1'b0, osc_in_i} - {1'b0, Center});
    assign prod   = diff_q * $signed({1'b0, e_q});
    assign scaled = prod >>> EnvBits;
    // |scaled| < Center for any gain, so truncation never wraps.
    assign out_d  = Center + scaled[BitDepth-1:0];

    logic unused_scaled_hi;
    assign unused_scaled_hi = ^scaled[ProdW-1:BitDepth];

    always_ff @(posedge sample_clock_i) begin
        if (!rst_ni) begin
            diff_q <= '0;
            e_q    <= '0;
            out_q  <= Center;
        end else begin
            diff_q <= diff_d;
            e_q    <= env_acc_q[AccBits-1 -: EnvBits];
            out_q  <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: tb/tb_envelope_adsr.sv
// Self-checking bench for envelope_adsr: directed scenarios followed by a
// randomized run, all compared every cycle against an arithmetic reference model.
module tb_envelope_adsr;

    localparam int IDLE = 0, ATTACK = 1, DECAY = 2, SUSTAIN = 3, RELEASE = 4;
    localparam int CENTER = 2047;
    localparam int ENV_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gate;
    logic [15:0] attack_rate, decay_rate, release_rate;
    logic [7:0]  sustain_level;
    logic [11:0] osc_in;
    logic [11:0] out;
    logic [7:0]  env_level;
    logic [2:0]  state;
    logic        busy;

    envelope_adsr dut (
        .sample_clock_i  (clk),
        .rst_ni          (rst_n),
        .gate_i          (gate),
        .attack_rate_i   (attack_rate),
        .decay_rate_i    (decay_rate),
        .sustain_level_i (sustain_level),
        .release_rate_i  (release_rate),
        .osc_in_i        (osc_in),
        .out_o           (out),
        .env_level_o     (env_level),
        .state_o         (state),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_phase = IDLE;
    int m_acc   = 0;
    int m_gprev = 0;
    int m_diff  = 0;
    int m_gain  = 0;
    int m_out   = CENTER;

    function automatic int floor_div256(input int x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int rise, s_acc;
        if (!rst_n) begin
            m_phase = IDLE; m_acc = 0; m_gprev = 0;
            m_diff = 0; m_gain = 0; m_out = CENTER;
            return;
        end
        m_out  = (CENTER + floor_div256(m_diff * m_gain)) & 4095;
        m_diff = int'(osc_in) - CENTER;
        m_gain = m_acc / 256;
        rise    = (gate && !m_gprev) ? 1 : 0;
        m_gprev = gate ? 1 : 0;
        s_acc   = int'(sustain_level) * 256;
        case (m_phase)
            IDLE: begin
                m_acc = 0;
                if (rise != 0) m_phase = ATTACK;
            end
            ATTACK: begin
                if (!gate) m_phase = RELEASE;
                else if (m_acc + int'(attack_rate) >= ENV_MAX) begin
                    m_acc = ENV_MAX; m_phase = DECAY;
                end else m_acc = m_acc + int'(attack_rate);
            end
            DECAY: begin
                if (!gate) m_phase = RELEASE;
                else if (m_acc <= s_acc + int'(decay_rate)) begin
                    m_acc = s_acc; m_phase = SUSTAIN;
                end else m_acc = m_acc - int'(decay_rate);
            end
            SUSTAIN: begin
                if (!gate) m_phase = RELEASE;
                else m_acc = s_acc;
            end
            default: begin
                if (rise != 0) m_phase = ATTACK;
                else if (m_acc <= int'(release_rate)) begin
                    m_acc = 0; m_phase = IDLE;
                end else m_acc = m_acc - int'(release_rate);
            end
        endcase
    endtask

    // One sample: clock edge, model update, compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("state", state, m_phase);
        check("env_level", env_level, m_acc / 256);
        check("busy", busy, (m_phase != IDLE) ? 1 : 0);
        check("out", out, m_out);
    endtask

    task automatic wait_phase(input int target, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (m_phase == target) break;
            step();
        end
        check(tag, state, target);
    endtask

    task automatic wait_acc(input int target, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (m_acc == target) break;
            step();
        end
        check(tag, env_level, target / 256);
    endtask

    initial begin
        // 1: reset with gate high and full-scale input
        rst_n = 1'b0; gate = 1'b1; osc_in = 12'd4095;
        attack_rate = 16'h1000; decay_rate = 16'h0100;
        release_rate = 16'h0800; sustain_level = 8'h80;
        #2;
        step(); step();
        check("reset_out", out, 2047);
        check("reset_state", state, IDLE);
        // Gate held through reset release counts as a rising edge
        rst_n = 1'b1;
        step();
        check("post_reset_attack", state, ATTACK);

        // 2: attack in 0x1000 steps
        for (int i = 0; i < 15; i++) step();
        check("attack_f000", env_level, 8'hF0);
        step();
        check("attack_to_decay", state, DECAY);
        check("attack_max", env_level, 8'hFF);

        // 3: decay to sustain, then live sustain tracking
        wait_phase(SUSTAIN, 200, "decay_to_sustain");
        check("sustain_80", env_level, 8'h80);
        sustain_level = 8'h40;
        step();
        check("sustain_track", env_level, 8'h40);
        sustain_level = 8'h80;
        step();

        // 4: release to idle in 16 steps
        gate = 1'b0;
        step();
        check("release_enter", state, RELEASE);
        for (int i = 0; i < 15; i++) step();
        check("release_running", state, RELEASE);
        step();
        check("release_idle", state, IDLE);

        // 4b: retrigger during release keeps the current level
        gate = 1'b1;
        step();
        wait_phase(SUSTAIN, 400, "resustain");
        gate = 1'b0;
        wait_acc(16'h4000, 50, "release_4000");
        gate = 1'b1;
        step();
        check("retrigger_state", state, ATTACK);
        check("retrigger_level", env_level, 8'h40);
        step();
        check("retrigger_step", env_level, 8'h50);

        // 5: gate drop during attack holds the level
        gate = 1'b0;
        wait_phase(IDLE, 200, "idle_before_drop");
        gate = 1'b1;
        step();
        wait_acc(16'h3000, 10, "attack_3000");
        gate = 1'b0;
        step();
        check("drop_state", state, RELEASE);
        check("drop_level", env_level, 8'h30);

        // 6: scaling at full sustain gain
        wait_phase(IDLE, 100, "idle_before_scale");
        sustain_level = 8'hFF;
        gate = 1'b1;
        step();
        wait_phase(SUSTAIN, 400, "full_sustain");
        osc_in = 12'd4095; step(); step();
        check("scale_top", out, 4087);
        osc_in = 12'd0; step(); step();
        check("scale_bottom", out, 7);
        osc_in = 12'd2047; step(); step();
        check("scale_center", out, 2047);
        gate = 1'b0;
        wait_phase(IDLE, 100, "idle_zero_gain");
        osc_in = 12'd3000; step(); step();
        check("zero_gain_hi", out, 2047);
        osc_in = 12'd100; step(); step();
        check("zero_gain_lo", out, 2047);

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            osc_in = 12'($urandom);
            rst_n  = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 11) == 0) gate = ~gate;
            if ($urandom_range(0, 63) == 0) begin
                attack_rate  = 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(2, 12));
                decay_rate   = 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(2, 12));
                release_rate = 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(2, 12));
                if ($urandom_range(0, 15) == 0) attack_rate = 16'd0;
                if ($urandom_range(0, 15) == 0) release_rate = 16'd0;
            end
            if ($urandom_range(0, 31) == 0) sustain_level = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
